text_writer: RTL

Sequential writer that turns the game's score, level and rows-cleared counters into ASCII character codes. It stores them in the on-screen character buffer that the text renderer reads out per pixel. On a start pulse it captures the three counters and converts each to decimal with a shared serial binary-to-BCD unit. It then streams the digit characters, and optionally the static labels, into the buffer's write port one character per cycle. It sits between game-state logic and the character buffer RAM, replacing per-pixel combinational division.

---
 rtl/text_pkg.sv | 67 ++++++
 rtl/bin2bcd_seq.sv | 45 ++++
 rtl/text_writer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants, label ROM contents, state/field enums and BCD helpers for text_writer.
package text_pkg;

  localparam int GRID_COLS = 80;

  localparam int SCORE_ROW = 25;
  localparam int LEVEL_ROW = 26;
  localparam int ROWS_ROW  = 27;
  localparam int DIGIT_COL = 18;

  localparam int SCORE_LABEL_COL = 12;
  localparam int LEVEL_LABEL_COL = 12;
  localparam int ROWS_LABEL_COL  = 5;
  localparam int SCORE_LABEL_LEN = 6;
  localparam int LEVEL_LABEL_LEN = 6;
  localparam int LABEL_LEN       = 25;

  localparam logic [2:0] SCORE_DIGITS = 3'd6;
  localparam logic [2:0] LEVEL_DIGITS = 3'd2;
  localparam logic [2:0] ROWS_DIGITS  = 3'd3;

  localparam logic [19:0] SCORE_MAX = 20'd999999;
  localparam logic [6:0]  LEVEL_MAX = 7'd99;
  localparam logic [9:0]  ROWS_MAX  = 10'd999;

  localparam logic [7:0] COLON_CODE = 8'h7C;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // "Score:" "Level:" "Rows Cleared:" in font codes (colon glyph 0x7C, blank 0x00)
  localparam logic [7:0] LABEL_CHARS [LABEL_LEN] = '{
    8'h53, 8'h63, 8'h6F, 8'h72, 8'h65, COLON_CODE,
    8'h4C, 8'h65, 8'h76, 8'h65, 8'h6C, COLON_CODE,
    8'h52, 8'h6F, 8'h77, 8'h73, 8'h00, 8'h43, 8'h6C, 8'h65, 8'h61, 8'h72, 8'h65, 8'h64, COLON_CODE
  };

  typedef enum logic [2:0] {ST_IDLE, ST_LABEL, ST_CONV, ST_WRITE, ST_DONE} state_t;
  typedef enum logic [1:0] {FIELD_SCORE, FIELD_LEVEL, FIELD_ROWS} field_t;

  function automatic logic [2:0] field_digits(input field_t f);
    case (f)
      FIELD_SCORE: return SCORE_DIGITS;
      FIELD_LEVEL: return LEVEL_DIGITS;
      FIELD_ROWS:  return ROWS_DIGITS;
      default:     return 3'd1;
    endcase
  endfunction

  function automatic int field_row(input field_t f);
    case (f)
      FIELD_SCORE: return SCORE_ROW;
      FIELD_LEVEL: return LEVEL_ROW;
      FIELD_ROWS:  return ROWS_ROW;
      default:     return SCORE_ROW;
    endcase
  endfunction

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the next left shift.
  function automatic logic [23:0] dabble_adjust(input logic [23:0] v);
    logic [23:0] r;
    r = 24'd0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial 20-bit binary-to-BCD converter; the start cycle performs the first of
// 20 double-dabble steps, so done and a valid bcd appear 20 cycles after start.
module bin2bcd_seq
  import text_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [19:0] bin,
  output logic [23:0] bcd,
  output logic        done
);

  logic [19:0] shreg;
  logic [4:0]  cnt;
  logic        active;

  // Shift/adjust datapath and step counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcd    <= 24'd0;
      shreg  <= 20'd0;
      cnt    <= 5'd0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd    <= {23'd0, bin[19]};
        shreg  <= {bin[18:0], 1'b0};
        cnt    <= 5'd19;
        active <= 1'b1;
      end else if (active) begin
        bcd   <= (dabble_adjust(bcd) << 5'd1) | {23'd0, shreg[19]};
        shreg <= shreg << 5'd1;
        cnt   <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/text_writer.sv
// Streams score/level/rows-cleared as decimal characters into the character buffer.
// Define TEXT_WRITER_LABELS_EN to also rewrite the static labels on every update.
module text_writer #(
  parameter int GRID_COLS = 80,
  parameter int ADDR_W    = 12
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [19:0]       score,
  input  logic [6:0]        level,
  input  logic [9:0]        rows_cleared,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  import text_pkg::*;

  function automatic logic [ADDR_W-1:0] cell_addr(input int row, input int col);
    return ADDR_W'(row * GRID_COLS + col);
  endfunction

  state_t state, state_nx;
  field_t field, field_nx;
  logic [4:0]  idx, idx_nx;
  logic [19:0] score_lat, score_sat, score_src;
  logic [6:0]  level_lat;
  logic [9:0]  rows_lat;

  logic        cvt_start, cvt_done;
  logic [19:0] cvt_bin;
  logic [23:0] cvt_bcd;

  logic              busy_nx, done_nx, wr_en_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [7:0]        wr_data_nx;
  logic [2:0]        sh;
  logic [3:0]        digit;

  bin2bcd_seq u_bcd (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (cvt_start),
    .bin     (cvt_bin),
    .bcd     (cvt_bcd),
    .done    (cvt_done)
  );

  assign score_sat = (score > SCORE_MAX) ? SCORE_MAX : score;

  // Sequencing: labels, then per field a conversion followed by its digit writes.
  always_comb begin
    state_nx  = state;
    field_nx  = field;
    idx_nx    = idx;
    cvt_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          field_nx = FIELD_SCORE;
          idx_nx   = 5'd0;
`ifdef TEXT_WRITER_LABELS_EN
          state_nx = ST_LABEL;
`else
          state_nx  = ST_CONV;
          cvt_start = 1'b1;
`endif
        end else begin
          state_nx = ST_IDLE;
        end
      end
`ifdef TEXT_WRITER_LABELS_EN
      ST_LABEL: begin
        if (idx == 5'(LABEL_LEN - 1)) begin
          state_nx  = ST_CONV;
          idx_nx    = 5'd0;
          cvt_start = 1'b1;
        end else begin
          idx_nx = idx + 5'd1;
        end
      end
`endif
      ST_CONV: begin
        if (cvt_done) begin
          state_nx = ST_WRITE;
          idx_nx   = 5'd0;
        end else begin
          state_nx = ST_CONV;
        end
      end
      ST_WRITE: begin
        if (idx == {2'd0, field_digits(field) - 3'd1}) begin
          idx_nx = 5'd0;
          if (field == FIELD_ROWS) begin
            state_nx = ST_DONE;
          end else begin
            field_nx  = (field == FIELD_SCORE) ? FIELD_LEVEL : FIELD_ROWS;
            state_nx  = ST_CONV;
            cvt_start = 1'b1;
          end
        end else begin
          idx_nx = idx + 5'd1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // The score conversion can start in the latch cycle itself, so bypass the latch there.
  always_comb begin
    score_src = (state == ST_IDLE) ? score_sat : score_lat;
    case (field_nx)
      FIELD_SCORE: cvt_bin = score_src;
      FIELD_LEVEL: cvt_bin = {13'd0, level_lat};
      FIELD_ROWS:  cvt_bin = {10'd0, rows_lat};
      default:     cvt_bin = 20'd0;
    endcase
  end

  // Output values for the cycle being entered; registered below.
  always_comb begin
    busy_nx    = (state_nx != ST_IDLE) && (state_nx != ST_DONE);
    done_nx    = (state_nx == ST_DONE);
    wr_en_nx   = 1'b0;
    wr_addr_nx = '0;
    wr_data_nx = 8'd0;
    sh         = field_digits(field_nx) - 3'd1 - idx_nx[2:0];
    case (sh)
      3'd0:    digit = cvt_bcd[3:0];
      3'd1:    digit = cvt_bcd[7:4];
      3'd2:    digit = cvt_bcd[11:8];
      3'd3:    digit = cvt_bcd[15:12];
      3'd4:    digit = cvt_bcd[19:16];
      3'd5:    digit = cvt_bcd[23:20];
      default: digit = 4'd0;
    endcase
    if (state_nx == ST_WRITE) begin
      wr_en_nx   = 1'b1;
      wr_addr_nx = cell_addr(field_row(field_nx), DIGIT_COL + int'(idx_nx));
      wr_data_nx = ASCII_ZERO + {4'd0, digit};
`ifdef TEXT_WRITER_LABELS_EN
    end else if (state_nx == ST_LABEL) begin
      wr_en_nx   = 1'b1;
      wr_data_nx = LABEL_CHARS[idx_nx];
      if (int'(idx_nx) < SCORE_LABEL_LEN) begin
        wr_addr_nx = cell_addr(SCORE_ROW, SCORE_LABEL_COL + int'(idx_nx));
      end else if (int'(idx_nx) < SCORE_LABEL_LEN + LEVEL_LABEL_LEN) begin
        wr_addr_nx = cell_addr(LEVEL_ROW, LEVEL_LABEL_COL + int'(idx_nx) - SCORE_LABEL_LEN);
      end else begin
        wr_addr_nx = cell_addr(ROWS_ROW,
                               ROWS_LABEL_COL + int'(idx_nx) - SCORE_LABEL_LEN - LEVEL_LABEL_LEN);
      end
`endif
    end else begin
      wr_en_nx = 1'b0;
    end
  end

  // State, input latches and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      field     <= FIELD_SCORE;
      idx       <= 5'd0;
      score_lat <= 20'd0;
      level_lat <= 7'd0;
      rows_lat  <= 10'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
    end else begin
      state   <= state_nx;
      field   <= field_nx;
      idx     <= idx_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      wr_en   <= wr_en_nx;
      wr_addr <= wr_addr_nx;
      wr_data <= wr_data_nx;
      if (state == ST_IDLE && start) begin
        score_lat <= score_sat;
        level_lat <= (level > LEVEL_MAX) ? LEVEL_MAX : level;
        rows_lat  <= (rows_cleared > ROWS_MAX) ? ROWS_MAX : rows_cleared;
      end
    end
  end

endmodule
